// File: rtl/scrisc_muldiv_pkg.sv
// Shared types and sizing for the SCRISC-16 iterative multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package scrisc_muldiv_pkg;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    localparam int MD_WIDTH = 16;
    localparam int MD_CNT_W = $clog2(MD_WIDTH);

endpackage

// File: rtl/muldiv_step.sv
// One multiply (shift-add) or restoring-divide (shift-subtract) iteration on a {hi,lo} pair.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module muldiv_step
    import scrisc_muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  muldiv_op_e       op,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           no_borrow;

    // mul: {acc,mplr} >> 1 after a conditional add; div: shift in dividend bit, trial subtract
    always_comb begin
        sum       = {1'b0, hi_i} + {1'b0, opnd_i};
        shifted   = {hi_i, lo_i[WIDTH-1]};
        no_borrow = (shifted >= {1'b0, opnd_i});
        diff      = shifted - {1'b0, opnd_i};
        hi_o      = hi_i;
        lo_o      = lo_i;
        if (op == OP_MUL) begin
            if (lo_i[0]) begin
                {hi_o, lo_o} = {sum, lo_i[WIDTH-1:1]};
            end else begin
                {hi_o, lo_o} = {1'b0, hi_i, lo_i[WIDTH-1:1]};
            end
        end else begin
            // the remainder after a successful subtract is below the divisor, so it fits in WIDTH bits
            if (no_borrow) begin
                hi_o = diff[WIDTH-1:0];
                lo_o = {lo_i[WIDTH-2:0], 1'b1};
            end else begin
                hi_o = shifted[WIDTH-1:0];
                lo_o = {lo_i[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 16x16 multiply / 16/16 divide with a one-cycle write-back request; MULDIV_SIGNED_EN adds sgn.
// Latency: accept in cycle 0, done/wb_en in cycle WIDTH+1 (divide by zero: cycle 2).
// Backpressure: busy high from the cycle after acceptance through DONE; start while busy is dropped.
module muldiv_unit
    import scrisc_muldiv_pkg::*;
#(
    parameter int WIDTH      = MD_WIDTH,
    parameter int REG_ADDR_W = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  op,
`ifdef MULDIV_SIGNED_EN
    input  logic                  sgn,
`endif
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    input  logic [REG_ADDR_W-1:0] dst,
    output logic                  busy,
    output logic                  done,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [2*WIDTH-1:0]    wb_data,
    output logic                  div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    muldiv_state_e         state_q, state_d;
    muldiv_op_e            op_q, op_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]      hi_q, hi_d;
    logic [WIDTH-1:0]      lo_q, lo_d;
    logic [WIDTH-1:0]      opnd_q, opnd_d;
    logic [WIDTH-1:0]      a_raw_q, a_raw_d;
    logic                  neg_hi_q, neg_hi_d;
    logic                  neg_lo_q, neg_lo_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  dbz_q, dbz_d;
    logic [REG_ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [2*WIDTH-1:0]    wb_data_q, wb_data_d;

    logic                  sgn_eff;
    logic                  a_neg;
    logic                  b_neg;
    logic [WIDTH-1:0]      a_mag;
    logic [WIDTH-1:0]      b_mag;
    logic [WIDTH-1:0]      step_hi;
    logic [WIDTH-1:0]      step_lo;
    logic [2*WIDTH-1:0]    step_pair;
    logic [2*WIDTH-1:0]    mul_res;
    logic [WIDTH-1:0]      quo_res;
    logic [WIDTH-1:0]      rem_res;

`ifdef MULDIV_SIGNED_EN
    assign sgn_eff = sgn;
`else
    assign sgn_eff = 1'b0;
`endif

    // Magnitudes are taken once at acceptance; the core iteration is always unsigned.
    assign a_neg = sgn_eff & a[WIDTH-1];
    assign b_neg = sgn_eff & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op     (op_q),
        .hi_i   (hi_q),
        .lo_i   (lo_q),
        .opnd_i (opnd_q),
        .hi_o   (step_hi),
        .lo_o   (step_lo)
    );

    // Sign fix-up applied to the final iteration output as it is captured for write-back.
    assign step_pair = {step_hi, step_lo};
    assign mul_res   = neg_lo_q ? -step_pair : step_pair;
    assign quo_res   = neg_lo_q ? -step_lo : step_lo;
    assign rem_res   = neg_hi_q ? -step_hi : step_hi;

    // Next-state: FSM sequencing, operand capture, iteration and result capture.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opnd_d    = opnd_q;
        a_raw_d   = a_raw_q;
        neg_hi_d  = neg_hi_q;
        neg_lo_d  = neg_lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    busy_d    = 1'b1;
                    op_d      = muldiv_op_e'(op);
                    cnt_d     = CNT_W'(WIDTH - 1);
                    wb_addr_d = dst;
                    a_raw_d   = a;
                    hi_d      = '0;
                    if (muldiv_op_e'(op) == OP_MUL) begin
                        // accumulator starts at zero, multiplier shifts out of lo
                        lo_d     = b_mag;
                        opnd_d   = a_mag;
                        neg_lo_d = a_neg ^ b_neg;
                        neg_hi_d = a_neg ^ b_neg;
                    end else begin
                        // partial remainder starts at zero, dividend shifts out of lo
                        lo_d     = a_mag;
                        opnd_d   = b_mag;
                        neg_lo_d = a_neg ^ b_neg;
                        neg_hi_d = a_neg;
                    end
                end
            end
            RUN: begin
                if (op_q == OP_DIV && opnd_q == '0) begin
                    // divide by zero: all-ones quotient, untouched dividend as remainder
                    state_d   = DONE;
                    done_d    = 1'b1;
                    dbz_d     = 1'b1;
                    cnt_d     = '0;
                    wb_data_d = {a_raw_q, {WIDTH{1'b1}}};
                end else begin
                    hi_d = step_hi;
                    lo_d = step_lo;
                    if (cnt_q == '0) begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        wb_data_d = (op_q == OP_MUL) ? mul_res : {rem_res, quo_res};
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight without write-back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= OP_MUL;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            opnd_q    <= '0;
            a_raw_q   <= '0;
            neg_hi_q  <= 1'b0;
            neg_lo_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            opnd_q    <= opnd_d;
            a_raw_q   <= a_raw_d;
            neg_hi_q  <= neg_hi_d;
            neg_lo_q  <= neg_lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign wb_en       = done_q;
    assign wb_addr     = wb_addr_q;
    assign wb_data     = wb_data_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, results, div-by-zero, busy drop, reset abort.
// Latency: n/a.
// Backpressure: n/a.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic        sgn;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  dst;
    logic        busy;
    logic        done;
    logic        wb_en;
    logic [1:0]  wb_addr;
    logic [31:0] wb_data;
    logic        div_by_zero;

    int n_checks;
    int n_fail;

    muldiv_unit #(
        .WIDTH      (16),
        .REG_ADDR_W (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
`ifdef MULDIV_SIGNED_EN
        .sgn         (sgn),
`endif
        .a           (a),
        .b           (b),
        .dst         (dst),
        .busy        (busy),
        .done        (done),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Issue one operation, then follow it to its done pulse and one cycle beyond.
    task automatic run_op(input string tag, input logic op_i, input logic sgn_i,
                          input logic [15:0] a_i, input logic [15:0] b_i, input logic [1:0] dst_i,
                          input logic [31:0] exp_data, input logic exp_dbz, input int exp_lat);
        int lat;
        start = 1'b1;
        op    = op_i;
        sgn   = sgn_i;
        a     = a_i;
        b     = b_i;
        dst   = dst_i;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 16'h5A5A;
        b     = 16'h0003;
        dst   = ~dst_i;
        lat   = 1;
        chk({tag, "_busy1"}, 64'(busy), 64'd1);
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_data"}, 64'(wb_data), 64'(exp_data));
        chk({tag, "_addr"}, 64'(wb_addr), 64'(dst_i));
        chk({tag, "_wben"}, 64'(wb_en), 64'd1);
        chk({tag, "_dbz"}, 64'(div_by_zero), 64'(exp_dbz));
        @(posedge clk);
        #1;
        chk({tag, "_idle"}, {61'd0, busy, wb_en, div_by_zero}, 64'd0);
        chk({tag, "_hold"}, 64'(wb_data), 64'(exp_data));
    endtask

    int rise_cnt, done_cnt, rise1, rise2, done1, done2;
    logic [31:0] data1, data2;
    logic prev_busy;
    int wb_seen;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        sgn   = 1'b0;
        a     = '0;
        b     = '0;
        dst   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {58'd0, busy, done, wb_en, div_by_zero, wb_addr}, 64'd0);
        chk("rst_data", 64'(wb_data), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_op("mul_ffff", 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 2'd1, 32'hFFFE_0001, 1'b0, 17);
        run_op("div_100_7", 1'b1, 1'b0, 16'd100, 16'd7, 2'd2, 32'h0002_000E, 1'b0, 17);
        run_op("div_zero", 1'b1, 1'b0, 16'h1234, 16'h0000, 2'd3, 32'h1234_FFFF, 1'b1, 2);
        run_op("mul_zero", 1'b0, 1'b0, 16'h0000, 16'hBEEF, 2'd0, 32'h0000_0000, 1'b0, 17);
        run_op("mul_1234", 1'b0, 1'b0, 16'h1234, 16'h0010, 2'd1, 32'h0001_2340, 1'b0, 17);
        run_op("div_ffff_1", 1'b1, 1'b0, 16'hFFFF, 16'h0001, 2'd2, 32'h0000_FFFF, 1'b0, 17);
        run_op("div_5_9", 1'b1, 1'b0, 16'd5, 16'd9, 2'd3, 32'h0005_0000, 1'b0, 17);

        // start held high: accepts only in cycles 0 and 18, operand change in cycle 5 is not seen by op 1
        rise_cnt  = 0;
        done_cnt  = 0;
        rise1     = -1;
        rise2     = -1;
        done1     = -1;
        done2     = -1;
        data1     = '0;
        data2     = '0;
        prev_busy = busy;
        op  = 1'b0;
        sgn = 1'b0;
        a   = 16'd3;
        b   = 16'd5;
        dst = 2'd2;
        for (int c = 0; c < 40; c++) begin
            start = (c < 36);
            if (c == 5) a = 16'd9;
            @(posedge clk);
            #1;
            if (busy && !prev_busy) begin
                rise_cnt++;
                if (rise_cnt == 1) rise1 = c + 1;
                if (rise_cnt == 2) rise2 = c + 1;
            end
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin done1 = c + 1; data1 = wb_data; end
                if (done_cnt == 2) begin done2 = c + 1; data2 = wb_data; end
            end
            prev_busy = busy;
        end
        start = 1'b0;
        chk("hold_accepts", 64'(rise_cnt), 64'd2);
        chk("hold_rise1", 64'(rise1), 64'd1);
        chk("hold_rise2", 64'(rise2), 64'd19);
        chk("hold_dones", 64'(done_cnt), 64'd2);
        chk("hold_done1", 64'(done1), 64'd17);
        chk("hold_done2", 64'(done2), 64'd35);
        chk("hold_data1", 64'(data1), 64'd15);
        chk("hold_data2", 64'(data2), 64'd45);
        repeat (2) @(posedge clk);
        #1;

        // reset in cycle 8 of a multiply aborts it with no write-back
        start = 1'b1;
        op    = 1'b0;
        a     = 16'h00FF;
        b     = 16'h00FF;
        dst   = 2'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("abort_busy_pre", 64'(busy), 64'd1);
        reset = 1'b1;
        #2;
        chk("abort_outs", {58'd0, busy, done, wb_en, div_by_zero, wb_addr}, 64'd0);
        chk("abort_data", 64'(wb_data), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wb_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (wb_en) wb_seen++;
        end
        chk("abort_no_wb", 64'(wb_seen), 64'd0);
        run_op("after_rst", 1'b0, 1'b0, 16'h00FF, 16'h00FF, 2'd3, 32'h0000_FE01, 1'b0, 17);

`ifdef MULDIV_SIGNED_EN
        run_op("smul_m7_3", 1'b0, 1'b1, 16'hFFF9, 16'h0003, 2'd1, 32'hFFFF_FFEB, 1'b0, 17);
        run_op("sdiv_m7_2", 1'b1, 1'b1, 16'hFFF9, 16'h0002, 2'd2, 32'hFFFF_FFFD, 1'b0, 17);
        run_op("umul_fff9_3", 1'b0, 1'b0, 16'hFFF9, 16'h0003, 2'd0, 32'h0002_FFEB, 1'b0, 17);
        run_op("sdiv_zero", 1'b1, 1'b1, 16'hFFF9, 16'h0000, 2'd3, 32'hFFF9_FFFF, 1'b1, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
